// File: rtl/multi_timer_pkg.sv
// Shared definitions for the multi-channel timer: bus encodings, register map, CTRL bit layout.
// Latency: n/a (package).
// Backpressure: n/a (package).
package multi_timer_pkg;

    localparam int ADDR_W      = 32;
    localparam int WORD_W      = 32;
    localparam int MEM_COUNT_W = 2;
    localparam int MEM_CODE_W  = 2;

    // Access size on the request bus.
    typedef enum logic [MEM_COUNT_W-1:0] {
        MEM_COUNT_NONE = 2'd0,
        MEM_COUNT_BYTE = 2'd1,
        MEM_COUNT_HALF = 2'd2,
        MEM_COUNT_WORD = 2'd3
    } mem_count_t;

    localparam logic [MEM_CODE_W-1:0] MEM_CODE_NONE    = 2'd0;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_OK      = 2'd1;
    localparam logic [MEM_CODE_W-1:0] MEM_CODE_INVALID = 2'd2;

    // Per-channel register window.
    localparam int CH_STRIDE = 16;
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_LOAD    = 2'd1;
    localparam logic [1:0] REG_COUNT   = 2'd2;
    localparam logic [1:0] REG_COMPARE = 2'd3;

    // CTRL bit positions.
    localparam int CTRL_EN      = 0;
    localparam int CTRL_LD      = 1;
    localparam int CTRL_DIR     = 2;
    localparam int CTRL_ONESHOT = 3;
    localparam int CTRL_IRQ_EN  = 4;
    localparam int CTRL_PRE_LSB = 8;

    // Register write request routed from the decoder to one channel.
    typedef struct packed {
        logic              vld;
        logic [1:0]        sel;
        logic [3:0]        be;
        logic [WORD_W-1:0] dat;
    } reg_wr_t;

    // Replace only the byte lanes selected by be.
    function automatic logic [WORD_W-1:0] merge_lanes(input logic [WORD_W-1:0] old_val,
                                                      input logic [WORD_W-1:0] new_val,
                                                      input logic [3:0]        be);
        logic [WORD_W-1:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_val[8*i +: 8] : old_val[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/multi_timer_channel.sv
// One timer channel: prescaler, up/down counter, compare, one-shot/periodic, byte-lane register writes.
// Latency: register writes take effect on the request edge; evt is combinational for the tick edge.
// Backpressure: none, every write is accepted on the edge it is presented.
//
// Ports: clk/areset; wr = decoded write for this channel; *_q = read views (zero-extended
// to WORD_W); evt = expire or compare event this cycle; irq_en = CTRL.IRQ_EN.
module multi_timer_channel
    import multi_timer_pkg::*;
#(
    parameter int CNT_W = 32,
    parameter int PRE_W = 8
) (
    input  logic              clk,
    input  logic              areset,
    input  reg_wr_t           wr,
    output logic [WORD_W-1:0] ctrl_q,
    output logic [WORD_W-1:0] load_q,
    output logic [WORD_W-1:0] count_q,
    output logic [WORD_W-1:0] compare_q,
    output logic              evt,
    output logic              irq_en
);

    logic             en;
    logic             dir;
    logic             oneshot;
    logic             irq_en_r;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic [CNT_W-1:0] load;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] compare;

    logic              ctrl_wr;
    logic              load_wr;
    logic              count_wr;
    logic              compare_wr;
    logic [WORD_W-1:0] ctrl_new;
    logic              ld;
    logic              tick;
    logic              tick_eff;
    logic              expire;
    logic [CNT_W-1:0]  tick_cnt;
    logic              unused_ctrl;

    always_comb begin
        ctrl_q                          = '0;
        ctrl_q[CTRL_EN]                 = en;
        ctrl_q[CTRL_DIR]                = dir;
        ctrl_q[CTRL_ONESHOT]            = oneshot;
        ctrl_q[CTRL_IRQ_EN]             = irq_en_r;
        ctrl_q[CTRL_PRE_LSB +: PRE_W]   = prescale;
    end

    assign load_q    = WORD_W'(load);
    assign count_q   = WORD_W'(count);
    assign compare_q = WORD_W'(compare);
    assign irq_en    = irq_en_r;

    always_comb begin
        ctrl_wr    = wr.vld && (wr.sel == REG_CTRL);
        load_wr    = wr.vld && (wr.sel == REG_LOAD);
        count_wr   = wr.vld && (wr.sel == REG_COUNT);
        compare_wr = wr.vld && (wr.sel == REG_COMPARE);
        ctrl_new   = merge_lanes(ctrl_q, wr.dat, wr.be);
        ld         = ctrl_wr && ctrl_new[CTRL_LD];

        tick   = en && (pre_cnt == prescale);
        expire = dir ? (count == '0) : (count == '1);
        if (expire) begin
            tick_cnt = oneshot ? count : load;
        end else begin
            tick_cnt = dir ? (count - CNT_W'(1)) : (count + CNT_W'(1));
        end
        // A bus write to COUNT or an LD strobe pre-empts the tick entirely,
        // including its event and any one-shot disable.
        tick_eff = tick && !count_wr && !ld;
        evt      = tick_eff && (expire || (tick_cnt == compare));
    end

    // Reserved CTRL bits are discarded on write.
    assign unused_ctrl = ^ctrl_new;

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            en       <= 1'b0;
            dir      <= 1'b0;
            oneshot  <= 1'b0;
            irq_en_r <= 1'b0;
            prescale <= '0;
            pre_cnt  <= '0;
            load     <= '0;
            count    <= '0;
            compare  <= '0;
        end else begin
            if (load_wr) begin
                load <= CNT_W'(merge_lanes(load_q, wr.dat, wr.be));
            end
            if (compare_wr) begin
                compare <= CNT_W'(merge_lanes(compare_q, wr.dat, wr.be));
            end
            if (ctrl_wr) begin
                en       <= ctrl_new[CTRL_EN];
                dir      <= ctrl_new[CTRL_DIR];
                oneshot  <= ctrl_new[CTRL_ONESHOT];
                irq_en_r <= ctrl_new[CTRL_IRQ_EN];
                prescale <= ctrl_new[CTRL_PRE_LSB +: PRE_W];
            end

            if (!en || tick) begin
                pre_cnt <= '0;
            end else begin
                pre_cnt <= pre_cnt + PRE_W'(1);
            end
            if (ld || (ctrl_wr && !ctrl_new[CTRL_EN])) begin
                pre_cnt <= '0;
            end

            if (count_wr) begin
                count <= CNT_W'(merge_lanes(count_q, wr.dat, wr.be));
            end else if (ld) begin
                count <= load;
            end else if (tick) begin
                count <= tick_cnt;
            end

            // One-shot expiry disables the channel even if CTRL is written this cycle.
            if (tick_eff && expire && oneshot) begin
                en <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_timer.sv
// Memory-mapped N_CH-channel timer: address decode, read mux, shared W1C STATUS, level irq.
// Latency: read data/response code one cycle after the request edge; o_irq one cycle after a flag.
// Backpressure: none, a request is accepted on every edge where count != NONE.
//
// Ports: clk, areset (async, active-high); i_req_* = request (addr, lane-aligned wr data,
// wr_en, access size); o_res_rd_data/o_res_code = registered response; o_irq = level interrupt.
module multi_timer
    import multi_timer_pkg::*;
#(
    parameter logic [ADDR_W-1:0] ADDR_START = '0,
    parameter int                N_CH       = 4,
    parameter int                CNT_W      = 32,
    parameter int                PRE_W      = 8
) (
    input  logic                   clk,
    input  logic                   areset,
    input  logic [ADDR_W-1:0]      i_req_addr,
    input  logic [WORD_W-1:0]      i_req_wr_data,
    input  logic                   i_req_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_req_count,
    output logic [WORD_W-1:0]      o_res_rd_data,
    output logic [MEM_CODE_W-1:0]  o_res_code,
    output logic                   o_irq
);

    localparam logic [ADDR_W-1:0] WIN_SIZE = ADDR_W'(CH_STRIDE * N_CH + 4);

    mem_count_t            req_cnt;
    logic [ADDR_W-5:0]     ch_field;
    logic [1:0]            word_sel;
    logic [1:0]            lane;
    logic                  req_vld;
    logic                  in_win;
    logic                  misalign;
    logic                  acc_ok;
    logic                  wr_ok;
    logic                  is_status;
    logic [3:0]            byte_en;
    logic [WORD_W-1:0]     rd_word;
    logic [N_CH-1:0]       status;
    logic [N_CH-1:0]       status_clr;
    logic [N_CH-1:0]       ch_evt;
    logic [N_CH-1:0]       ch_irq_en;
    logic [3:0][WORD_W-1:0] ch_rd [N_CH];

    assign req_cnt = mem_count_t'(i_req_count);

    always_comb begin
        // Addresses below ADDR_START wrap to large offsets and fall outside the window.
        {ch_field, word_sel, lane} = i_req_addr - ADDR_START;
        req_vld   = (req_cnt != MEM_COUNT_NONE);
        in_win    = ({ch_field, word_sel, lane} < WIN_SIZE);
        misalign  = ((req_cnt == MEM_COUNT_HALF) && lane[0]) ||
                    ((req_cnt == MEM_COUNT_WORD) && (lane != 2'd0));
        acc_ok    = req_vld && in_win && !misalign;
        wr_ok     = acc_ok && i_req_wr_en;
        is_status = (ch_field == (ADDR_W-4)'(N_CH));

        case (req_cnt)
            MEM_COUNT_BYTE: byte_en = 4'b0001 << lane;
            MEM_COUNT_HALF: byte_en = lane[1] ? 4'b1100 : 4'b0011;
            MEM_COUNT_WORD: byte_en = 4'b1111;
            default:        byte_en = 4'b0000;
        endcase

        rd_word = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (ch_field == (ADDR_W-4)'(c)) begin
                rd_word = ch_rd[c][word_sel];
            end
        end
        if (is_status) begin
            rd_word = WORD_W'(status);
        end

        status_clr = (wr_ok && is_status && byte_en[0]) ? i_req_wr_data[N_CH-1:0] : '0;
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        reg_wr_t ch_wr;

        assign ch_wr = '{vld: wr_ok && (ch_field == (ADDR_W-4)'(c)),
                         sel: word_sel,
                         be:  byte_en,
                         dat: i_req_wr_data};

        multi_timer_channel #(
            .CNT_W (CNT_W),
            .PRE_W (PRE_W)
        ) u_ch (
            .clk       (clk),
            .areset    (areset),
            .wr        (ch_wr),
            .ctrl_q    (ch_rd[c][REG_CTRL]),
            .load_q    (ch_rd[c][REG_LOAD]),
            .count_q   (ch_rd[c][REG_COUNT]),
            .compare_q (ch_rd[c][REG_COMPARE]),
            .evt       (ch_evt[c]),
            .irq_en    (ch_irq_en[c])
        );
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            status        <= '0;
            o_irq         <= 1'b0;
            o_res_rd_data <= '0;
            o_res_code    <= MEM_CODE_NONE;
        end else begin
            // A hardware event wins over a same-cycle clear of that bit.
            status <= (status & ~status_clr) | ch_evt;
            o_irq  <= |(status & ch_irq_en);

            if (!req_vld) begin
                o_res_code    <= MEM_CODE_NONE;
                o_res_rd_data <= '0;
            end else if (!acc_ok) begin
                o_res_code    <= MEM_CODE_INVALID;
                o_res_rd_data <= '0;
            end else begin
                o_res_code    <= MEM_CODE_OK;
                o_res_rd_data <= i_req_wr_en ? '0 : rd_word;
            end
        end
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer: register access, counting modes, STATUS/irq, bus errors, reset.
// Latency: checks sample one time unit after the response edge.
// Backpressure: n/a.
module tb_multi_timer;
    import multi_timer_pkg::*;

    logic        clk;
    logic        areset;
    logic [31:0] req_addr;
    logic [31:0] req_wr_data;
    logic        req_wr_en;
    logic [1:0]  req_count;
    logic [31:0] res_rd_data;
    logic [1:0]  res_code;
    logic        irq;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    localparam logic [1:0] C_NONE = 2'd0;
    localparam logic [1:0] C_BYTE = 2'd1;
    localparam logic [1:0] C_HALF = 2'd2;
    localparam logic [1:0] C_WORD = 2'd3;
    localparam logic [31:0] OK  = 32'd1;
    localparam logic [31:0] INV = 32'd2;

    multi_timer #(
        .ADDR_START (32'h0),
        .N_CH       (4),
        .CNT_W      (32),
        .PRE_W      (8)
    ) dut (
        .clk           (clk),
        .areset        (areset),
        .i_req_addr    (req_addr),
        .i_req_wr_data (req_wr_data),
        .i_req_wr_en   (req_wr_en),
        .i_req_count   (req_count),
        .o_res_rd_data (res_rd_data),
        .o_res_code    (res_code),
        .o_irq         (irq)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic xfer(input logic [31:0] a, input logic [31:0] d, input logic w, input logic [1:0] c);
        req_addr    = a;
        req_wr_data = d;
        req_wr_en   = w;
        req_count   = c;
        @(posedge clk);
        #1;
        req_count = C_NONE;
        req_wr_en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] c);
        xfer(a, d, 1'b1, c);
    endtask

    task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
        xfer(a, 32'h0, 1'b0, C_WORD);
        chk(tag, res_rd_data, exp);
    endtask

    task automatic idle(input int n);
        req_count = C_NONE;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        areset      = 1'b1;
        req_addr    = '0;
        req_wr_data = '0;
        req_wr_en   = 1'b0;
        req_count   = C_NONE;

        // Reset state
        #12;
        chk("rst_code", 32'(res_code), 32'(MEM_CODE_NONE));
        chk("rst_rd", res_rd_data, 32'h0);
        chk("rst_irq", 32'(irq), 32'h0);
        @(negedge clk);
        areset = 1'b0;
        rd_chk("rst_count0", 32'h08, 32'h0);
        chk("rst_read_code", 32'(res_code), OK);

        // Load and LD strobe via byte write on ch0
        wr(32'h04, 32'hdeadbeef, C_WORD);
        chk("load_wr_code", 32'(res_code), OK);
        wr(32'h00, 32'h00000002, C_BYTE);
        rd_chk("ld_count", 32'h08, 32'hdeadbeef);
        chk("ld_count_code", 32'(res_code), OK);
        rd_chk("ld_ctrl_reads0", 32'h00, 32'h0);

        // ch3 compare match with a W1C on the same edge
        wr(32'h3C, 32'd5, C_WORD);
        wr(32'h30, 32'h11, C_WORD);           // EN | IRQ_EN, up, prescale 0
        idle(4);                              // count 1..4
        wr(32'h40, 32'h8, C_WORD);            // count -> 5 on this edge
        rd_chk("cmp_status_kept", 32'h40, 32'h8);
        chk("cmp_irq_hi", 32'(irq), 32'h1);
        wr(32'h40, 32'h8, C_WORD);
        chk("cmp_irq_still_hi", 32'(irq), 32'h1);
        rd_chk("cmp_status_clr", 32'h40, 32'h0);
        chk("cmp_irq_lo", 32'(irq), 32'h0);
        rd_chk("cmp_count_run", 32'h38, 32'd8);

        // ch2 one-shot up, prescale 2
        wr(32'h28, 32'hfffffffe, C_WORD);
        wr(32'h20, 32'h00000209, C_WORD);     // EN | ONESHOT | PRESCALE=2
        rd_chk("os_c1", 32'h28, 32'hfffffffe);
        rd_chk("os_c2", 32'h28, 32'hfffffffe);
        rd_chk("os_c3", 32'h28, 32'hfffffffe);
        rd_chk("os_c4", 32'h28, 32'hffffffff);
        rd_chk("os_ctrl_en", 32'h20, 32'h00000209);
        idle(1);
        rd_chk("os_ctrl_off", 32'h20, 32'h00000208);
        rd_chk("os_count_hold", 32'h28, 32'hffffffff);
        rd_chk("os_status", 32'h40, 32'h4);

        // Bus errors and partial writes
        rd_chk("err_pre", 32'h04, 32'hdeadbeef);
        rd_chk("err_oow_rd", 32'h44, 32'h0);
        chk("err_oow_code", 32'(res_code), INV);
        rd_chk("err_mis_rd", 32'h02, 32'h0);
        chk("err_mis_code", 32'(res_code), INV);
        wr(32'h06, 32'hffffffff, C_WORD);
        chk("err_miswr_code", 32'(res_code), INV);
        rd_chk("err_nowrite", 32'h04, 32'hdeadbeef);
        wr(32'h06, 32'h12340000, C_HALF);
        chk("half_code", 32'(res_code), OK);
        rd_chk("half_load", 32'h04, 32'h1234beef);
        xfer(32'h04, 32'h0, 1'b0, C_NONE);
        chk("none_code", 32'(res_code), 32'(MEM_CODE_NONE));
        chk("none_rd", res_rd_data, 32'h0);

        // ch1 down periodic, prescale 0
        wr(32'h1C, 32'hffffffff, C_WORD);
        wr(32'h14, 32'd3, C_WORD);
        wr(32'h10, 32'h6, C_WORD);            // LD | DIR
        wr(32'h10, 32'h15, C_WORD);           // EN | DIR | IRQ_EN
        rd_chk("dn_3", 32'h18, 32'd3);
        rd_chk("dn_2", 32'h18, 32'd2);
        rd_chk("dn_1", 32'h18, 32'd1);
        rd_chk("dn_0", 32'h18, 32'd0);
        chk("dn_irq_before", 32'(irq), 32'h0);
        rd_chk("dn_reload", 32'h18, 32'd3);
        chk("dn_irq_after", 32'(irq), 32'h1);
        rd_chk("dn_status", 32'h40, 32'h6);

        // Reset mid-count
        #2;
        areset = 1'b1;
        #1;
        chk("mrst_irq", 32'(irq), 32'h0);
        chk("mrst_rd", res_rd_data, 32'h0);
        chk("mrst_code", 32'(res_code), 32'(MEM_CODE_NONE));
        repeat (2) @(negedge clk);
        areset = 1'b0;
        rd_chk("mrst_count1", 32'h18, 32'h0);
        rd_chk("mrst_ctrl1", 32'h10, 32'h0);
        rd_chk("mrst_status", 32'h40, 32'h0);
        idle(5);
        rd_chk("mrst_idle", 32'h18, 32'h0);
        rd_chk("mrst_load0", 32'h04, 32'h0);
        chk("mrst_irq_idle", 32'(irq), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
Name: multi_timer

Overview:
Memory-mapped timer peripheral with N_CH independent counter channels on the processor's request/response memory bus. Each channel has prescaler, direction, one-shot/periodic mode, load value, compare register and interrupt. A shared status register collects per-channel event flags; o_irq is the OR of enabled flags. Replaces the single-channel timer on the peripheral bus.

Parameters:
ADDR_START, 0, byte base address of the register window
N_CH, 4, number of channels (1..8)
CNT_W, 32, counter width (1..`WORD_W); unused upper read bits return 0
PRE_W, 8, prescaler field width (1..16)

Ports:
clk  in  1  clock
areset  in  1  asynchronous reset, active-high
i_req_addr  in  `ADDR_W  byte address
i_req_wr_data  in  `WORD_W  write data, lane-aligned to the word
i_req_wr_en  in  1  1 = write, 0 = read
i_req_count  in  `MEM_COUNT_W  access size: NONE/BYTE/HALF/WORD
o_res_rd_data  out  `WORD_W  read data, registered
o_res_code  out  `MEM_CODE_W  response code, registered
o_irq  out  1  level interrupt

Behaviour:
- Window: channel c at ADDR_START+16*c. +0 CTRL, +4 LOAD, +8 COUNT, +C COMPARE. STATUS at ADDR_START+16*N_CH. Window size 16*N_CH+4.
- CTRL: [0] EN, [1] LD (write-1 strobe, reads 0), [2] DIR (0 up, 1 down), [3] ONESHOT, [4] IRQ_EN, [8+:PRE_W] PRESCALE.
- STATUS[c]: event flag, write-1-to-clear; bits >= N_CH read 0.
- Access: request sampled every clk edge where count != NONE. Writes commit on that edge; only addressed byte lanes are written. Read data and code valid the cycle after. Reads have no side effects.
- Response: count NONE -> MEM_CODE_NONE, rd_data 0. Valid -> MEM_CODE_OK. Address outside window or misaligned (HALF on odd, WORD not on multiple of 4) -> MEM_CODE_INVALID, no write, rd_data 0.
- Reset (async): all registers, prescaler counters and STATUS = 0. o_res_rd_data = 0, o_res_code = MEM_CODE_NONE, o_irq = 0. Reset mid-operation aborts everything immediately. First request is accepted on the first edge after deassertion.
- Prescaler: pre_cnt[c] increments each cycle while EN. When pre_cnt == PRESCALE: tick, and pre_cnt -> 0. PRESCALE=0 gives a tick every cycle. Clearing EN freezes COUNT and resets pre_cnt to 0.
- On tick, up mode: COUNT == max (all ones CNT_W) -> expire, else COUNT+1.
- On tick, down mode: COUNT == 0 -> expire, else COUNT-1.
- Expire, periodic: COUNT <- LOAD, STATUS[c] set.
- Expire, ONESHOT: COUNT holds, EN cleared, STATUS[c] set.
- Compare: on a tick where the new COUNT == COMPARE, STATUS[c] set.
- Priority per channel per cycle (highest first): bus write to COUNT > LD strobe (COUNT <- LOAD, pre_cnt <- 0) > tick. A CTRL write with LD=1 uses the LOAD value before any same-cycle write (LOAD is a separate address, so no conflict exists).
- STATUS: a hardware set in the same cycle as a W1C clear of that bit wins (bit stays 1).
- o_irq = |(STATUS[c] & IRQ_EN[c]), registered, so it asserts one cycle after the flag.
- Arithmetic is modulo 2^CNT_W. Writes to COUNT/LOAD/COMPARE keep only the low CNT_W bits.

Decomposition:
- Shared header (alongside mem_codes.vh): register offsets, CTRL bit indices, MEM_CODE_NONE/OK/INVALID if not already defined, channel stride 16.
- One sub-module: timer_channel (prescaler, counter, compare, mode logic, event pulse, byte-lane register writes). Top decodes the address, muxes read data, owns STATUS and o_irq; one generate instance per channel.

Test Plan:
- Load/reload: ch0 LOAD=32'hdeadbeef, CTRL LD=1 via byte write -> COUNT reads deadbeef next cycle, CTRL reads LD=0, code OK.
- Down periodic: ch1 LOAD=3, DIR=1, EN, PRESCALE=0 -> COUNT 3,2,1,0,3; STATUS[1] sets on reload edge; IRQ_EN=1 -> o_irq high one cycle later.
- One-shot up with prescale: ch2 COUNT=32'hfffffffe, PRESCALE=2, ONESHOT -> ticks every 3 cycles; at max, expire holds COUNT, EN reads 0, STATUS[2]=1.
- Compare and W1C collision: ch3 COMPARE=5, count up from 0. Write STATUS=8 on the match cycle -> bit 3 stays 1. Write 8 later -> bit 3 clears, o_irq falls.
- Bus errors: read ADDR_START+16*N_CH+4 and a WORD read at offset 2 -> MEM_CODE_INVALID, rd_data 0, no state change. Write HALF 16'h1234 to LOAD+2 -> LOAD upper half only.
- Reset mid-count: assert areset while ch1 is running with o_irq high -> all reads 0, o_irq 0 immediately. After release, the count stays idle.
